spi_fl_sched: RTL
=================

Name: spi_fl_sched

Overview:
- Command scheduler sitting in front of spi_master_fl.
- Shares the flash controller between two requesters:
  - port 0: a host command port with full frame descriptor;
  - port 1: an XIP read-fetch port, address only.
- Arbitrates round-robin and drives the master's controller interface.
- For program/erase commands it inserts a Write-Enable (WREN) frame before the command and Read-Status polling after it, then returns result data to the granted requester.

Parameters:
- WREN_CMD, 8'h06, write-enable opcode.
- RDSR_CMD, 8'h05, read-status opcode.
- CT_CMDONLY, 3'b000, commtype for command-only frames (WREN).
- CT_CMDRD, 3'b010, commtype for command plus read data without address (RDSR).
- XIP_CMD, 8'h0b, opcode for port-1 fetches.
- XIP_CT, 3'b110, commtype for port-1 fetches.
- XIP_DUMMY, 4'd8, dummy cycles for port-1 fetches.
- POLL_MAX, 16, maximum RDSR polls before the error flag is raised.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- r0_req  in  1  host request; held until r0_done
- r0_command  in  8  opcode
- r0_address  in  24  flash address
- r0_data_in  in  32  write data
- r0_commtype  in  3  frame type
- r0_ndata_bits  in  7  data bit count
- r0_dummy_cycles  in  4  dummy cycles
- r0_frame_struct  in  10  frame structure
- r0_wr  in  1  1 = program/erase: wrap the command with WREN and status polling
- r0_done  out  1  one-cycle completion pulse
- r0_rdata  out  32  read data, valid from r0_done until the next r0_done
- r0_err  out  1  poll timeout flag, valid with r0_done
- r1_req  in  1  XIP fetch request; held until r1_done
- r1_addr  in  24  fetch address
- r1_done  out  1  one-cycle completion pulse
- r1_rdata  out  32  fetched word
- m_command  out  8  to master command
- m_address  out  24  to master address
- m_data_in  out  32  to master data_in
- m_commtype  out  3  to master commtype
- m_ndata_bits  out  7  to master ndata_bits
- m_dummy_cycles  out  4  to master dummy_cycles
- m_frame_struct  out  10  to master frame_struct
- m_validflag  out  1  frame start strobe
- m_tready  in  1  master idle/ready
- m_data_out  in  32  master read data
- m_validflag_out  in  1  master frame-complete pulse

Behaviour:
- Reset (rst low, asynchronous):
  - state IDLE;
  - all outputs 0, including r0_err and both rdata registers;
  - last-grant flag = 1, so port 0 wins the first tie;
  - poll counter 0.
- Reset mid-frame aborts without any done pulse. The master must be reset alongside.
- States: IDLE, WREN, WAIT_WREN, CMD, WAIT_CMD, POLL, WAIT_POLL, DONE.
- IDLE:
  - Requests are sampled only here.
  - One requester active: it wins.
  - Both active: the port not granted last wins. Update the last-grant flag.
  - The winner's descriptor is latched into the m_* registers.
  - Port 1 descriptor: command XIP_CMD, commtype XIP_CT, address r1_addr, ndata_bits 32, dummy_cycles XIP_DUMMY, frame_struct 0, data_in 0.
  - Next state: WREN if port 0 with r0_wr=1, else CMD.
- Issue states (WREN, CMD, POLL):
  - Wait for m_tready=1, then assert m_validflag for exactly one cycle and move to the matching WAIT_* state.
  - m_* descriptor outputs are stable from one cycle before the strobe until m_validflag_out.
  - WREN frame: command WREN_CMD, commtype CT_CMDONLY.
  - POLL frame: command RDSR_CMD, commtype CT_CMDRD, ndata_bits 8, dummy_cycles 0.
  - The host descriptor is restored for CMD.
- WAIT_* states advance only on m_validflag_out.
  - WAIT_WREN goes to CMD.
  - WAIT_CMD:
    - latches m_data_out into the granted port's rdata;
    - goes to POLL if r0_wr, else DONE.
  - WAIT_POLL:
    - m_data_out[0]=0 (WIP clear): go to DONE.
    - Else poll counter +1; if the counter reaches POLL_MAX, set err and go to DONE; otherwise go to POLL.
- DONE:
  - One-cycle pulse on the granted port's done signal.
  - r0_err reflects the timeout result; it is cleared for a non-timeout completion.
  - Poll counter cleared; return to IDLE.
- A request still high in the cycle after done is treated as a new request.
- An m_validflag_out arriving outside WAIT_* states is ignored.
- m_tready low during an issue state stalls indefinitely; there is no timeout.
- Minimum latency, non-write command with m_tready high: req to m_validflag = 2 cycles; m_validflag_out to done = 2 cycles.

Test Plan:
- r1_req with r1_addr=24'h555555 and m_tready=1:
  - one strobe with command 8'h0b, commtype 3'b110, 32 bits, 8 dummy cycles;
  - model returns 32'hA0A0A0A3;
  - r1_done pulses once with r1_rdata=32'hA0A0A0A3.
- r0 and r1 requested in the same cycle, both held:
  - grant order is r0, r1, r0, r1;
  - exactly one m_validflag per frame;
  - no frame issued before the previous m_validflag_out.
- r0_wr=1, command 8'h02, address 24'h5a5a11, data 32'hdf000000, status model returns 8'h01, 8'h01, 8'h00:
  - frame sequence 06, 02, 05, 05, 05;
  - r0_done with r0_err=0.
- Same stimulus but status always 8'h01:
  - exactly 16 RDSR frames;
  - r0_done with r0_err=1.
- m_tready held low for 50 cycles in an issue state:
  - m_validflag stays 0 and the descriptor is stable;
  - the strobe occurs 1 cycle after tready rises.
- rst driven low during WAIT_CMD:
  - all outputs 0 immediately;
  - no done pulse;
  - the next request runs normally after release.

Source files
------------

// File: rtl/spi_fl_sched.sv
// spi_fl_sched: round-robin scheduler that shares one spi_master_fl between
// a host command port (port 0) and an XIP read-fetch port (port 1).
// Program/erase commands from the host are wrapped in a WREN frame before
// them and RDSR polling after them. Polling ends when WIP clears or after
// POLL_MAX polls, whichever comes first.
module spi_fl_sched #(
    parameter logic [7:0] WREN_CMD   = 8'h06,
    parameter logic [7:0] RDSR_CMD   = 8'h05,
    parameter logic [2:0] CT_CMDONLY = 3'b000,
    parameter logic [2:0] CT_CMDRD   = 3'b010,
    parameter logic [7:0] XIP_CMD    = 8'h0b,
    parameter logic [2:0] XIP_CT     = 3'b110,
    parameter logic [3:0] XIP_DUMMY  = 4'd8,
    parameter int         POLL_MAX   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_req,
    input  logic [7:0]  r0_command,
    input  logic [23:0] r0_address,
    input  logic [31:0] r0_data_in,
    input  logic [2:0]  r0_commtype,
    input  logic [6:0]  r0_ndata_bits,
    input  logic [3:0]  r0_dummy_cycles,
    input  logic [9:0]  r0_frame_struct,
    input  logic        r0_wr,
    output logic        r0_done,
    output logic [31:0] r0_rdata,
    output logic        r0_err,
    input  logic        r1_req,
    input  logic [23:0] r1_addr,
    output logic        r1_done,
    output logic [31:0] r1_rdata,
    output logic [7:0]  m_command,
    output logic [23:0] m_address,
    output logic [31:0] m_data_in,
    output logic [2:0]  m_commtype,
    output logic [6:0]  m_ndata_bits,
    output logic [3:0]  m_dummy_cycles,
    output logic [9:0]  m_frame_struct,
    output logic        m_validflag,
    input  logic        m_tready,
    input  logic [31:0] m_data_out,
    input  logic        m_validflag_out
);

    localparam int PW = $clog2(POLL_MAX + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_WREN, S_WAIT_WREN, S_CMD, S_WAIT_CMD, S_POLL, S_WAIT_POLL, S_DONE
    } state_t;

    state_t        state_reg, state_next;
    logic          grant_reg, grant_next;          // 0 = port 0, 1 = port 1
    logic          last_grant_reg, last_grant_next;
    logic          wr_reg, wr_next;
    logic          timeout_reg, timeout_next;
    logic [PW-1:0] poll_cnt_reg, poll_cnt_next, poll_inc;
    // host fields overwritten by the WREN/RDSR frames, kept for the real command
    logic [7:0]    cmd_save_reg, cmd_save_next;
    logic [2:0]    ct_save_reg, ct_save_next;
    logic [6:0]    nb_save_reg, nb_save_next;
    logic [3:0]    dc_save_reg, dc_save_next;
    logic [7:0]    m_command_reg, m_command_next;
    logic [23:0]   m_address_reg, m_address_next;
    logic [31:0]   m_data_in_reg, m_data_in_next;
    logic [2:0]    m_commtype_reg, m_commtype_next;
    logic [6:0]    m_ndata_bits_reg, m_ndata_bits_next;
    logic [3:0]    m_dummy_cycles_reg, m_dummy_cycles_next;
    logic [9:0]    m_frame_struct_reg, m_frame_struct_next;
    logic          m_validflag_reg, m_validflag_next;
    logic          r0_done_reg, r0_done_next;
    logic [31:0]   r0_rdata_reg, r0_rdata_next;
    logic          r0_err_reg, r0_err_next;
    logic          r1_done_reg, r1_done_next;
    logic [31:0]   r1_rdata_reg, r1_rdata_next;
    logic          pick1;

    assign poll_inc = poll_cnt_reg + PW'(1);

    // Next-state, arbitration and descriptor sequencing
    always_comb begin
        state_next          = state_reg;
        grant_next          = grant_reg;
        last_grant_next     = last_grant_reg;
        wr_next             = wr_reg;
        timeout_next        = timeout_reg;
        poll_cnt_next       = poll_cnt_reg;
        cmd_save_next       = cmd_save_reg;
        ct_save_next        = ct_save_reg;
        nb_save_next        = nb_save_reg;
        dc_save_next        = dc_save_reg;
        m_command_next      = m_command_reg;
        m_address_next      = m_address_reg;
        m_data_in_next      = m_data_in_reg;
        m_commtype_next     = m_commtype_reg;
        m_ndata_bits_next   = m_ndata_bits_reg;
        m_dummy_cycles_next = m_dummy_cycles_reg;
        m_frame_struct_next = m_frame_struct_reg;
        m_validflag_next    = 1'b0;
        r0_done_next        = 1'b0;
        r0_rdata_next       = r0_rdata_reg;
        r0_err_next         = r0_err_reg;
        r1_done_next        = 1'b0;
        r1_rdata_next       = r1_rdata_reg;
        // port 1 wins when alone, or on a tie when port 0 was served last
        pick1               = r1_req && (!r0_req || !last_grant_reg);

        case (state_reg)
            S_IDLE: begin
                if (r0_req || r1_req) begin
                    grant_next      = pick1;
                    last_grant_next = pick1;
                    if (pick1) begin
                        wr_next             = 1'b0;
                        m_command_next      = XIP_CMD;
                        m_address_next      = r1_addr;
                        m_data_in_next      = 32'd0;
                        m_commtype_next     = XIP_CT;
                        m_ndata_bits_next   = 7'd32;
                        m_dummy_cycles_next = XIP_DUMMY;
                        m_frame_struct_next = 10'd0;
                        state_next          = S_CMD;
                    end else begin
                        wr_next             = r0_wr;
                        cmd_save_next       = r0_command;
                        ct_save_next        = r0_commtype;
                        nb_save_next        = r0_ndata_bits;
                        dc_save_next        = r0_dummy_cycles;
                        m_address_next      = r0_address;
                        m_data_in_next      = r0_data_in;
                        m_ndata_bits_next   = r0_ndata_bits;
                        m_dummy_cycles_next = r0_dummy_cycles;
                        m_frame_struct_next = r0_frame_struct;
                        if (r0_wr) begin
                            m_command_next  = WREN_CMD;
                            m_commtype_next = CT_CMDONLY;
                            state_next      = S_WREN;
                        end else begin
                            m_command_next  = r0_command;
                            m_commtype_next = r0_commtype;
                            state_next      = S_CMD;
                        end
                    end
                end
            end
            S_WREN, S_CMD, S_POLL: begin
                if (m_tready) begin
                    m_validflag_next = 1'b1;
                    state_next = (state_reg == S_WREN) ? S_WAIT_WREN :
                                 (state_reg == S_CMD)  ? S_WAIT_CMD  : S_WAIT_POLL;
                end
            end
            S_WAIT_WREN: begin
                if (m_validflag_out) begin
                    m_command_next      = cmd_save_reg;
                    m_commtype_next     = ct_save_reg;
                    m_ndata_bits_next   = nb_save_reg;
                    m_dummy_cycles_next = dc_save_reg;
                    state_next          = S_CMD;
                end
            end
            S_WAIT_CMD: begin
                if (m_validflag_out) begin
                    if (grant_reg) r1_rdata_next = m_data_out;
                    else           r0_rdata_next = m_data_out;
                    if (wr_reg) begin
                        m_command_next      = RDSR_CMD;
                        m_commtype_next     = CT_CMDRD;
                        m_ndata_bits_next   = 7'd8;
                        m_dummy_cycles_next = 4'd0;
                        state_next          = S_POLL;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_WAIT_POLL: begin
                if (m_validflag_out) begin
                    if (!m_data_out[0]) begin
                        state_next = S_DONE;
                    end else begin
                        poll_cnt_next = poll_inc;
                        if (poll_inc == POLL_LAST) begin
                            timeout_next = 1'b1;
                            state_next   = S_DONE;
                        end else begin
                            state_next = S_POLL;
                        end
                    end
                end
            end
            S_DONE: begin
                if (grant_reg) begin
                    r1_done_next = 1'b1;
                end else begin
                    r0_done_next = 1'b1;
                    r0_err_next  = timeout_reg;
                end
                timeout_next  = 1'b0;
                poll_cnt_next = '0;
                state_next    = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State and output registers; asynchronous reset abandons any frame in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg          <= S_IDLE;
            grant_reg          <= 1'b0;
            last_grant_reg     <= 1'b1;
            wr_reg             <= 1'b0;
            timeout_reg        <= 1'b0;
            poll_cnt_reg       <= '0;
            cmd_save_reg       <= 8'd0;
            ct_save_reg        <= 3'd0;
            nb_save_reg        <= 7'd0;
            dc_save_reg        <= 4'd0;
            m_command_reg      <= 8'd0;
            m_address_reg      <= 24'd0;
            m_data_in_reg      <= 32'd0;
            m_commtype_reg     <= 3'd0;
            m_ndata_bits_reg   <= 7'd0;
            m_dummy_cycles_reg <= 4'd0;
            m_frame_struct_reg <= 10'd0;
            m_validflag_reg    <= 1'b0;
            r0_done_reg        <= 1'b0;
            r0_rdata_reg       <= 32'd0;
            r0_err_reg         <= 1'b0;
            r1_done_reg        <= 1'b0;
            r1_rdata_reg       <= 32'd0;
        end else begin
            state_reg          <= state_next;
            grant_reg          <= grant_next;
            last_grant_reg     <= last_grant_next;
            wr_reg             <= wr_next;
            timeout_reg        <= timeout_next;
            poll_cnt_reg       <= poll_cnt_next;
            cmd_save_reg       <= cmd_save_next;
            ct_save_reg        <= ct_save_next;
            nb_save_reg        <= nb_save_next;
            dc_save_reg        <= dc_save_next;
            m_command_reg      <= m_command_next;
            m_address_reg      <= m_address_next;
            m_data_in_reg      <= m_data_in_next;
            m_commtype_reg     <= m_commtype_next;
            m_ndata_bits_reg   <= m_ndata_bits_next;
            m_dummy_cycles_reg <= m_dummy_cycles_next;
            m_frame_struct_reg <= m_frame_struct_next;
            m_validflag_reg    <= m_validflag_next;
            r0_done_reg        <= r0_done_next;
            r0_rdata_reg       <= r0_rdata_next;
            r0_err_reg         <= r0_err_next;
            r1_done_reg        <= r1_done_next;
            r1_rdata_reg       <= r1_rdata_next;
        end
    end

    assign m_command      = m_command_reg;
    assign m_address      = m_address_reg;
    assign m_data_in      = m_data_in_reg;
    assign m_commtype     = m_commtype_reg;
    assign m_ndata_bits   = m_ndata_bits_reg;
    assign m_dummy_cycles = m_dummy_cycles_reg;
    assign m_frame_struct = m_frame_struct_reg;
    assign m_validflag    = m_validflag_reg;
    assign r0_done        = r0_done_reg;
    assign r0_rdata       = r0_rdata_reg;
    assign r0_err         = r0_err_reg;
    assign r1_done        = r1_done_reg;
    assign r1_rdata       = r1_rdata_reg;

endmodule
